prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_INST, default 200: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8: width of the word address; MAX_INST <= 2**ADDR_W.
REQ-003 SHALL have ports: CLK  input  1  sole clock, all state on posedge.
REQ-004 SHALL have ports: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: rx_valid  input  1  one-cycle strobe, a byte is present on rx_data (UART receiver output, no backpressure).
REQ-006 SHALL have ports: rx_data  input  8  received byte.
REQ-007 SHALL have ports: restart  input  1  abort or reload request, sampled each cycle.
REQ-008 SHALL have ports: wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have ports: wr_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have ports: wr_data  output  32  assembled instruction word.
REQ-011 SHALL have ports: busy  output  1  high in HEADER/BODY/CHECK with at least one byte consumed.
REQ-012 SHALL have ports: done  output  1  level, program fully loaded; the core may leave INIT.
REQ-013 SHALL have ports: err  output  1  level, load rejected.

Function
REQ-014 Stream format SHALL be: 4-byte word count N, then N words, all big-endian (first byte = bits 31:24).
REQ-015 States SHALL be HEADER, BODY, CHECK, DONE, ERROR; reset state is HEADER.
REQ-016 A 2-bit byte counter SHALL advance only on rx_valid in HEADER/BODY/CHECK and wrap 3->0 at word completion.
REQ-017 HEADER, 4th byte: if N > MAX_INST go to ERROR; if N = 0 go to CHECK (macro on) or DONE; else go to BODY with word index 0.
REQ-018 BODY, 4th byte of word k: in the next cycle wr_en=1, wr_addr=k, wr_data=assembled word; latency is exactly 1 cycle.
REQ-019 After word N-1 is written, the block SHALL go to CHECK (macro on) or DONE in the same cycle wr_en is high.
REQ-020 wr_en SHALL never be high for two consecutive cycles; wr_addr and wr_data hold their last values while wr_en=0.
REQ-021 In DONE and ERROR, rx_valid SHALL be ignored; done or err holds until restart or reset.
REQ-022 restart=1 in any state SHALL return the block to HEADER next cycle, clearing counters, done, err and pending wr_en; restart wins over a simultaneous rx_valid, and that byte is dropped.
REQ-023 Words already written before an abort SHALL NOT be erased; the next load overwrites them.
REQ-024 done and err SHALL never be high simultaneously.

Reset
REQ-025 RST_N low SHALL asynchronously force HEADER, byte and word counters 0, and wr_en/busy/done/err=0, wr_addr=0, wr_data=0.
REQ-026 Reset deassertion mid-stream SHALL treat the next byte as the first header byte.

Configuration
REQ-027 With PROG_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all header and body bytes, then expect one checksum byte in CHECK; a match goes to DONE, a mismatch goes to ERROR.
REQ-028 Without PROG_LOADER_CHECKSUM_EN, the CHECK state and XOR register SHALL be absent, and a completed load goes directly to DONE.

Structure
REQ-029 A shared package SHALL hold the state enum, the MAX_INST default and the header/word byte-count constant (4).
REQ-030 One sub-module, byte_packer (shift-in 4 bytes to 32-bit word plus complete flag), is natural; the FSM and counters stay in prog_loader.

Verification
REQ-031 Send 00 00 00 02, 20 01 00 05, 08 00 00 00 -> wr_en at addr 0 data 0x20010005, then addr 1 data 0x08000000; done=1 after the last write.
REQ-032 Header 00 00 00 C9 (201 > 200) -> err=1, no wr_en, and later bytes are ignored.
REQ-033 Header 00 00 00 00 -> done=1 one cycle after the 4th byte (macro off), with no writes.
REQ-034 restart asserted in the same cycle as the 2nd byte of word 1 -> HEADER next cycle, busy=0; the re-sent full stream loads correctly.
REQ-035 RST_N pulsed low mid-BODY -> all outputs 0 immediately, asynchronously; the following stream loads from addr 0.
REQ-036 Macro on, stream 00 00 00 01, 12 34 56 78, checksum 0x09 -> done=1; the same stream with checksum 0x08 -> err=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int unsigned MAX_INST_DEF = 200;
    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned BYTE_CNT_W   = 2;
    localparam int unsigned WORD_W       = 32;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_BODY,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Shifts received bytes into a big-endian word; the word is complete on the
// strobe that carries the last byte, so it is presented combinationally.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              last,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              complete_c
);

    localparam int unsigned PART_W = (WORD_BYTES - 1) * 8;

    logic [PART_W-1:0] partial;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            partial <= '0;
        end else if (clr) begin
            partial <= '0;
        end else if (shift_en) begin
            partial <= {partial[PART_W-9:0], byte_in};
        end
    end

    assign word_c     = {partial, byte_in};
    assign complete_c = shift_en & last;

endmodule

// File: rtl/prog_loader.sv
// Loads a big-endian word-count-prefixed program from a UART byte stream
// into instruction memory. PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_INST = MAX_INST_DEF,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e                 state;
    logic [BYTE_CNT_W-1:0]  byte_cnt;
    logic [ADDR_W-1:0]      word_idx;
    logic [ADDR_W-1:0]      last_idx;
    logic [WORD_W-1:0]      word_c;
    logic                   complete_c;
    logic                   active_c;
    logic                   take_c;
    logic                   last_byte_c;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]             xor_q;
`endif

    // Bytes are only consumed while loading; restart drops a coincident byte.
`ifdef PROG_LOADER_CHECKSUM_EN
    assign active_c = (state == ST_HEADER) || (state == ST_BODY) || (state == ST_CHECK);
`else
    assign active_c = (state == ST_HEADER) || (state == ST_BODY);
`endif
    assign take_c      = rx_valid & ~restart & active_c;
    assign last_byte_c = (byte_cnt == BYTE_CNT_W'(WORD_BYTES - 1));

    byte_packer u_packer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clr        (restart),
        .shift_en   (take_c),
        .last       (last_byte_c),
        .byte_in    (rx_data),
        .word_c     (word_c),
        .complete_c (complete_c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_HEADER;
            byte_cnt <= '0;
            word_idx <= '0;
            last_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                state    <= ST_HEADER;
                byte_cnt <= '0;
                word_idx <= '0;
                last_idx <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
                err      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                xor_q    <= '0;
`endif
            end else if (take_c) begin
                byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                busy     <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                xor_q    <= xor_q ^ rx_data;
`endif
                case (state)
                    ST_HEADER: begin
                        if (complete_c) begin
                            if (word_c > WORD_W'(MAX_INST)) begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else if (word_c == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
`endif
                            end else begin
                                state    <= ST_BODY;
                                word_idx <= '0;
                                last_idx <= ADDR_W'(word_c - WORD_W'(1));
                            end
                        end
                    end
                    ST_BODY: begin
                        if (complete_c) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= word_idx;
                            wr_data  <= word_c;
                            word_idx <= word_idx + ADDR_W'(1);
                            if (word_idx == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    // Running XOR including this byte must cancel to zero.
                    ST_CHECK: begin
                        busy <= 1'b0;
                        if ((xor_q ^ rx_data) == 8'h00) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader against a byte-stream reference model.
// Honours PROG_LOADER_CHECKSUM_EN in the same way as the design.
module tb_prog_loader;

    localparam int unsigned MAX_INST = 200;
    localparam int unsigned ADDR_W   = 8;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              restart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_data;

    always #5 CLK = ~CLK;

    prog_loader #(.MAX_INST(MAX_INST), .ADDR_W(ADDR_W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .restart  (restart),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr_n();
        return {stream[0], stream[1], stream[2], stream[3]};
    endfunction

    function automatic logic [7:0] xor_upto(input int last);
        logic [7:0] x = 8'h00;
        for (int k = 0; k <= last; k++) x ^= stream[k];
        return x;
    endfunction

    // 0 = still loading, 1 = done, 2 = error, after stream bytes 0..i consumed.
    function automatic int status_after(input int i);
        logic [31:0] n;
        int          ni;
        if (i < 3) return 0;
        n = hdr_n();
        if (n > MAX_INST) return 2;
        ni = int'(n);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (i < 4 + 4 * ni) return 0;
        return (xor_upto(3 + 4 * ni) == stream[4 + 4 * ni]) ? 1 : 2;
`else
        return (i >= 3 + 4 * ni) ? 1 : 0;
`endif
    endfunction

    function automatic bit write_at(input int i);
        logic [31:0] n;
        if (i < 7) return 1'b0;
        n = hdr_n();
        if (n > MAX_INST) return 1'b0;
        return (i <= 3 + 4 * int'(n)) && (((i - 4) % 4) == 3);
    endfunction

    task automatic idle_cycle();
        @(posedge CLK); #1;
        check_val("idle_wr_en", 32'(wr_en), 32'd0);
        check_val("hold_addr", 32'(wr_addr), exp_addr);
        check_val("hold_data", wr_data, exp_data);
    endtask

    task automatic send_byte(input int i, input int gap);
        int st;
        bit wr;
        for (int g = 0; g < gap; g++) idle_cycle();
        rx_valid = 1'b1;
        rx_data  = stream[i];
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        wr = write_at(i);
        check_val("wr_en", 32'(wr_en), 32'(wr));
        if (wr) begin
            exp_addr = 32'((i - 4) / 4);
            exp_data = {stream[i-3], stream[i-2], stream[i-1], stream[i]};
        end
        check_val("wr_addr", 32'(wr_addr), exp_addr);
        check_val("wr_data", wr_data, exp_data);
        st = status_after(i);
        check_val("done", 32'(done), 32'(st == 1));
        check_val("err", 32'(err), 32'(st == 2));
        check_val("busy", 32'(busy), 32'(st == 0));
    endtask

    task automatic run_stream();
        for (int i = 0; i < stream.size(); i++) send_byte(i, int'($urandom_range(0, 2)));
        idle_cycle();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge CLK); #1;
        restart = 1'b0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_hold_addr", 32'(wr_addr), exp_addr);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_val({tag, "_wr_data"}, wr_data, 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic build_random(input logic [31:0] n, input int junk);
        logic [7:0] sum;
        stream.delete();
        for (int b = 3; b >= 0; b--) stream.push_back(n[8*b +: 8]);
        if (n <= MAX_INST) begin
            for (int k = 0; k < 4 * int'(n); k++) stream.push_back(8'($urandom));
`ifdef PROG_LOADER_CHECKSUM_EN
            sum = xor_upto(stream.size() - 1);
            if ($urandom_range(0, 2) == 0) sum ^= 8'($urandom_range(1, 255));
            stream.push_back(sum);
`else
            sum = 8'h00;
`endif
        end else begin
            sum = 8'h00;
        end
        for (int j = 0; j < junk; j++) stream.push_back(8'($urandom) ^ sum);
    endtask

    initial begin
        logic [31:0] n;
        int          r;
        RST_N    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        exp_addr = 32'd0;
        exp_data = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;

        // Two-word program
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                   8'h08, 8'h00, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(xor_upto(11));
`endif
        run_stream();

        // Oversized count is rejected and trailing bytes ignored
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'hC9, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_stream();

        // Empty program
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        stream.push_back(8'hA5);
        run_stream();

        // Restart coincident with 2nd byte of word 1, then full reload
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(xor_upto(11));
`endif
        for (int i = 0; i < 9; i++) send_byte(i, 0);
        rx_valid = 1'b1;
        rx_data  = stream[9];
        restart  = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_wr_en", 32'(wr_en), 32'd0);
        run_stream();

        // Asynchronous reset mid-body
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 10; i++) send_byte(i, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_addr = 32'd0;
        exp_data = 32'd0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(xor_upto(7));
`endif
        run_stream();

`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run_stream();
        pulse_restart();
        stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_stream();
`endif

        // Randomized loads including count boundaries
        for (int t = 0; t < 25; t++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: begin
                    n = $urandom;
                    if (n <= MAX_INST) n = n + 32'h100;
                end
                1: n = 32'(MAX_INST);
                2: n = 32'(MAX_INST + 1);
                default: n = 32'($urandom_range(0, 10));
            endcase
            pulse_restart();
            build_random(n, int'($urandom_range(0, 3)));
            run_stream();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
